// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and stall controller for the ID/EX pipeline register and the
// registers around it in the 5-stage MIPS core. It handles three cases:
//   - a load-use hazard between the instruction in ID and a load in EX
//     (one bubble is inserted),
//   - a taken branch (the two wrong-path slots are squashed),
//   - data memory busy (the whole front of the pipeline is frozen).
// A branch that resolves while memory is busy is remembered and applied in
// the first cycle after memory becomes free.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   : stall_cycles / flush_events performance counters are built
//   undefined : no counter logic; both ports read 0
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   ID_Rs_addr/ID_Rt_addr source register fields of the instruction in ID
//   ID_uses_Rt            instruction in ID reads Rt
//   EX_MemRead/EX_Rt_addr load indication and destination from ID/EX
//   branch_taken          branch resolved taken in EX this cycle
//   mem_busy              data memory not ready, MEM stage must hold
//   PC_write, IF_ID_write load enables (combinational)
//   IF_ID_flush, ID_EX_flush, ID_EX_hold, EX_MEM_hold  strobes (combinational)
//   state                 FSM state for debug: RUN=0 LOAD_STALL=1 FLUSH=2
//                         MEM_WAIT=3
//   mem_timeout           sticky, mem_busy held for MAX_WAIT or more cycles
//   stall_cycles          cycles with PC_write=0 (saturating)
//   flush_events          applied branch flushes (saturating)
//
// Handshake note: there is no valid/ready pair here. All strobes are level
// signals that are valid in the same cycle as the inputs that cause them;
// the pipeline registers sample them on the next rising edge.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int WAIT_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs_addr,
    input  logic [4:0]       ID_Rt_addr,
    input  logic             ID_uses_Rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt_addr,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             ID_EX_hold,
    output logic             EX_MEM_hold,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);

    state_t            curState;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitInc;
    logic              pendingFlush;
    logic              loadUse;
    logic              loadUseEff;
    logic              branchReq;

    assign loadUse = EX_MemRead && (EX_Rt_addr != 5'd0) &&
                     ((EX_Rt_addr == ID_Rs_addr) ||
                      (ID_uses_Rt && (EX_Rt_addr == ID_Rt_addr)));

    // The slot in ID right after a flush is a NOP, so its register fields
    // are meaningless and must not raise a load-use stall.
    assign loadUseEff = loadUse && (curState != FLUSH);
    assign branchReq  = branch_taken || pendingFlush;

    assign waitInc = (waitCnt == '1) ? waitCnt : waitCnt + WAIT_W'(1);

    assign state       = curState;

    // Strobes: priority is reset > mem_busy > branch > load-use > normal.
    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        ID_EX_hold  = 1'b0;
        EX_MEM_hold = 1'b0;
        if (rst) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (mem_busy) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_hold  = 1'b1;
            EX_MEM_hold = 1'b1;
        end else if (branchReq) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (loadUseEff) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState     <= RUN;
            waitCnt      <= '0;
            pendingFlush <= 1'b0;
            mem_timeout  <= 1'b0;
        end else if (mem_busy) begin
            curState <= MEM_WAIT;
            waitCnt  <= waitInc;
            if (waitInc >= MAX_WAIT_V) begin
                mem_timeout <= 1'b1;
            end
            if (branch_taken) begin
                pendingFlush <= 1'b1;
            end
        end else begin
            waitCnt <= '0;
            if (branchReq) begin
                curState     <= FLUSH;
                pendingFlush <= 1'b0;
            end else if (loadUseEff) begin
                curState <= LOAD_STALL;
            end else begin
                curState <= RUN;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
    logic             flushApplied;

    assign flushApplied = !mem_busy && branchReq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (!PC_write && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if (flushApplied && (flushCnt != '1)) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stallCnt;
    assign flush_events = flushCnt;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
